// File: rtl/i2c_regmap_if.sv
// Slave-to-regmap link: SCL-domain address/data/strobes in, rdata back out.
interface i2c_regmap_if;
  logic       i2c_active;
  logic       wr_en_wdata;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output i2c_active, wr_en_wdata, addr, wdata, input rdata);
  modport slave  (input i2c_active, wr_en_wdata, addr, wdata, output rdata);
endinterface

// File: rtl/i2c_regmap.sv
// Clock-domain register map behind i2c_slave: synchronises the slave's SCL-domain
// strobes and address into clk, holds config/IRQ/count/ID registers, returns rdata.
module i2c_regmap #(
  parameter int         NUM_RW   = 8,
  parameter logic [7:0] RW_RESET = 8'h00,
  parameter logic [7:0] CHIP_ID  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  i2c_regmap_if.slave         bus,
  input  logic [6:0]          irq_src,
  output logic [8*NUM_RW-1:0] cfg,
  output logic                wr_strobe,
  output logic [7:0]          wr_addr,
  output logic                txn_done,
  output logic                irq
);
  localparam logic [7:0] A_STATUS = 8'hF0;
  localparam logic [7:0] A_MASK   = 8'hF1;
  localparam logic [7:0] A_COUNT  = 8'hF2;
  localparam logic [7:0] A_ID     = 8'hFF;

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} wr_state_e;

  logic [2:0] wsync_q;
  logic [3:0] async_q;
  logic [7:0] a1_q, a2_q, a3_q;
  logic       wr_rise, txn_fall;

  // Write sync resets high so a strobe already asserted at release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsync_q <= 3'b111;
      async_q <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
    end else begin
      wsync_q <= {wsync_q[1:0], bus.wr_en_wdata};
      async_q <= {async_q[2:0], bus.i2c_active};
      a1_q    <= bus.addr;
      a2_q    <= a1_q;
      a3_q    <= a2_q;
    end
  end

  assign wr_rise  = wsync_q[1] & ~wsync_q[2];
  assign txn_fall = async_q[3] & ~async_q[2];

  wr_state_e  state_q;
  logic [7:0] hold_addr_q, hold_data_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      case (state_q)
        IDLE:    if (wr_rise) state_q <= CAPTURE;
        CAPTURE: begin
          // addr/wdata have been stable for at least two clk by now
          hold_addr_q <= bus.addr;
          hold_data_q <= bus.wdata;
          state_q     <= COMMIT;
        end
        COMMIT: begin
          wr_strobe_q <= 1'b1;
          wr_addr_q   <= hold_addr_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic                   commit, overrun;
  logic [NUM_RW-1:0][7:0] cfg_q, cfg_d;
  logic [7:0]             status_q, status_d;
  logic [7:0]             mask_q, mask_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [7:0]             rd_val, clr;
  logic                   irq_q, irq_d;
  logic                   txn_done_q, txn_done_d;

  assign commit  = (state_q == COMMIT);
  assign overrun = wr_rise & (state_q != IDLE);

  always_comb begin
    cfg_d   = cfg_q;
    mask_d  = mask_q;
    count_d = count_q;
    clr     = 8'h00;
    if (commit) begin
      count_d = count_q + 8'd1;
      for (int i = 0; i < NUM_RW; i++)
        if (hold_addr_q == 8'(i)) cfg_d[i] = hold_data_q;
      case (hold_addr_q)
        A_STATUS: clr    = hold_data_q;
        A_MASK:   mask_d = hold_data_q;
        default:  ;
      endcase
    end
    // set after clear so a coincident source keeps its bit
    status_d = (status_q & ~clr) | {overrun, irq_src};
    irq_d    = |(status_q & mask_q);
    txn_done_d = txn_fall;
  end

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_RW; i++)
      if (a2_q == 8'(i)) rd_val = cfg_q[i];
    case (a2_q)
      A_STATUS: rd_val = status_q;
      A_MASK:   rd_val = mask_q;
      A_COUNT:  rd_val = count_q;
      A_ID:     rd_val = CHIP_ID;
      default:  ;
    endcase
    // only update on two matching samples, which rejects skewed multi-bit captures
    rdata_d = (a2_q == a3_q) ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= {NUM_RW{RW_RESET}};
      status_q   <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      txn_done_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      txn_done_q <= txn_done_d;
    end
  end

  assign cfg       = cfg_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign txn_done  = txn_done_q;
  assign irq       = irq_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_i2c_regmap.sv
// Bench for i2c_regmap: expected commits are queued as writes are driven and
// consumed when wr_strobe appears; register contents are checked through rdata.
module tb_i2c_regmap;
  localparam int         NUM_RW   = 8;
  localparam logic [7:0] RW_RESET = 8'h00;
  localparam logic [7:0] CHIP_ID  = 8'hA5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [6:0]          irq_src = '0;
  logic [8*NUM_RW-1:0] cfg;
  logic                wr_strobe, txn_done, irq;
  logic [7:0]          wr_addr;

  i2c_regmap_if bus();

  i2c_regmap #(.NUM_RW(NUM_RW), .RW_RESET(RW_RESET), .CHIP_ID(CHIP_ID)) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq_src(irq_src), .cfg(cfg),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .txn_done(txn_done), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  wr_t        exp_q[$];
  wr_t        mon_e;
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_cfg [NUM_RW];
  logic [7:0] m_cnt;
  logic [7:0] rv;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected wr_addr=%h required=no_strobe", wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.addr) begin
          bad++;
          $display("FAIL wr_addr got=%h exp=%h", wr_addr, mon_e.addr);
        end
        if (int'(mon_e.addr) < NUM_RW) begin
          total++;
          if (cfg[8*int'(mon_e.addr) +: 8] !== mon_e.data) begin
            bad++;
            $display("FAIL commit_data reg=%h got=%h exp=%h", mon_e.addr,
                     cfg[8*int'(mon_e.addr) +: 8], mon_e.data);
          end
        end
      end
    end
  end

  function automatic logic [8*NUM_RW-1:0] model_cfg();
    logic [8*NUM_RW-1:0] v;
    for (int i = 0; i < NUM_RW; i++) v[8*i +: 8] = m_cfg[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_RW; i++) m_cfg[i] = RW_RESET;
    m_cnt = 8'h00;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int width);
    exp_q.push_back(wr_t'{addr: a, data: d});
    if (int'(a) < NUM_RW) m_cfg[int'(a)] = d;
    m_cnt++;
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.wr_en_wdata = 1'b1;
    repeat (width) @(negedge clk);
    bus.wr_en_wdata = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_at(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.addr = a;
    repeat (5) @(negedge clk);
    v = bus.rdata;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
    total++; if (cfg !== {NUM_RW{RW_RESET}}) begin bad++; $display("FAIL rst_cfg got=%h", cfg); end
    total++; if (wr_strobe !== 1'b0 || txn_done !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL rst_pulses strobe=%b txn=%b irq=%b exp=0", wr_strobe, txn_done, irq); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr); end
    rst = 1'b0;
    read_at(8'hF0, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", rv); end
    read_at(8'hF2, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL rst_count got=%h exp=00", rv); end
    read_at(8'hFF, rv);
    total++; if (rv !== CHIP_ID) begin bad++; $display("FAIL chip_id got=%h exp=%h", rv, CHIP_ID); end
  endtask

  task automatic test_write();
    exp_q.push_back(wr_t'{addr: 8'h02, data: 8'h3C});
    m_cfg[2] = 8'h3C; m_cnt++;
    @(negedge clk);
    bus.addr = 8'h02; bus.wdata = 8'h3C; bus.wr_en_wdata = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (cfg[23:16] !== RW_RESET) begin bad++; $display("FAIL wr_early got=%h exp=%h", cfg[23:16], RW_RESET); end
    @(negedge clk);
    total++; if (cfg[23:16] !== 8'h3C) begin bad++; $display("FAIL wr_e5 got=%h exp=3c", cfg[23:16]); end
    total++; if (wr_strobe !== 1'b1) begin bad++; $display("FAIL wr_strobe_e5 got=%b exp=1", wr_strobe); end
    @(negedge clk);
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL wr_strobe_width got=%b exp=0", wr_strobe); end
    repeat (3) @(negedge clk);
    bus.wr_en_wdata = 1'b0;
    repeat (6) @(negedge clk);
    read_at(8'hF2, rv);
    total++; if (rv !== m_cnt) begin bad++; $display("FAIL wr_count got=%h exp=%h", rv, m_cnt); end
    do_write(8'h00, 8'h11, 3);
    do_write(8'h07, 8'hE4, 2);
    do_write(8'h40, 8'h77, 2);
    total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL wr_cfg got=%h exp=%h", cfg, model_cfg()); end
    read_at(8'h07, rv);
    total++; if (rv !== 8'hE4) begin bad++; $display("FAIL rd_reg7 got=%h exp=e4", rv); end
    read_at(8'h40, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL rd_unmapped got=%h exp=00", rv); end
    read_at(8'hF2, rv);
    total++; if (rv !== m_cnt) begin bad++; $display("FAIL wr_count4 got=%h exp=%h", rv, m_cnt); end
  endtask

  task automatic test_read_filter();
    logic [7:0] seq [3];
    seq[0] = 8'hF3; seq[1] = 8'hF7; seq[2] = 8'hFF;
    do_write(8'hF1, 8'h08, 2);
    repeat (5) @(negedge clk);
    total++; if (bus.rdata !== 8'h08) begin bad++; $display("FAIL rd_mask got=%h exp=08", bus.rdata); end
    for (int i = 0; i < 3; i++) begin
      bus.addr = seq[i];
      @(negedge clk);
      total++; if (bus.rdata !== 8'h08) begin bad++; $display("FAIL rd_glitch step=%0d got=%h exp=08", i, bus.rdata); end
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.rdata !== 8'h08 && bus.rdata !== CHIP_ID) begin
        bad++; $display("FAIL rd_settle cyc=%0d got=%h exp=08_or_a5", i, bus.rdata);
      end
      @(negedge clk);
    end
    total++; if (bus.rdata !== CHIP_ID) begin bad++; $display("FAIL rd_final got=%h exp=a5", bus.rdata); end
  endtask

  task automatic test_irq();
    @(negedge clk); irq_src = 7'h08;
    @(negedge clk); irq_src = 7'h00;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_lag1 got=%b exp=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag2 got=%b exp=1", irq); end
    read_at(8'hF0, rv);
    total++; if (rv !== 8'h08) begin bad++; $display("FAIL irq_status got=%h exp=08", rv); end
    irq_src = 7'h08;
    do_write(8'hF0, 8'h08, 2);
    repeat (2) @(negedge clk);
    total++; if (bus.rdata !== 8'h08) begin bad++; $display("FAIL w1c_setwins got=%h exp=08", bus.rdata); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_setwins_irq got=%b exp=1", irq); end
    irq_src = 7'h00;
    do_write(8'hF0, 8'h08, 2);
    repeat (2) @(negedge clk);
    total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL w1c_clear got=%h exp=00", bus.rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_clear_irq got=%b exp=0", irq); end
  endtask

  task automatic test_txn_done();
    @(negedge clk); bus.i2c_active = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (txn_done !== 1'b0) begin bad++; $display("FAIL txn_rise got=%b exp=0", txn_done); end
    bus.i2c_active = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (txn_done !== 1'b0) begin bad++; $display("FAIL txn_early got=%b exp=0", txn_done); end
    @(negedge clk);
    total++; if (txn_done !== 1'b1) begin bad++; $display("FAIL txn_pulse got=%b exp=1", txn_done); end
    @(negedge clk);
    total++; if (txn_done !== 1'b0) begin bad++; $display("FAIL txn_width got=%b exp=0", txn_done); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(wr_t'{addr: 8'h03, data: 8'h55});
    m_cfg[3] = 8'h55; m_cnt++;
    @(negedge clk); bus.addr = 8'h03; bus.wdata = 8'h55; bus.wr_en_wdata = 1'b1;
    @(negedge clk); bus.wr_en_wdata = 1'b0;
    @(negedge clk); bus.wr_en_wdata = 1'b1;
    @(negedge clk); bus.wr_en_wdata = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (cfg[31:24] !== 8'h55) begin bad++; $display("FAIL b2b_data got=%h exp=55", cfg[31:24]); end
    read_at(8'hF0, rv);
    total++; if (rv !== 8'h80) begin bad++; $display("FAIL b2b_overrun got=%h exp=80", rv); end
    read_at(8'hF2, rv);
    total++; if (rv !== m_cnt) begin bad++; $display("FAIL b2b_count got=%h exp=%h", rv, m_cnt); end
    do_write(8'hF0, 8'h80, 2);
    read_at(8'hF0, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL b2b_clear got=%h exp=00", rv); end
  endtask

  task automatic test_reset_hold();
    @(negedge clk);
    bus.addr = 8'h02; bus.wdata = 8'h99; bus.wr_en_wdata = 1'b1; rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    bus.wr_en_wdata = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL hold_cfg got=%h exp=%h", cfg, model_cfg()); end
    read_at(8'hF2, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL hold_count got=%h exp=00", rv); end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 255; i++) do_write(8'h80, 8'(i), 2);
    read_at(8'hF2, rv);
    total++; if (rv !== 8'hFF) begin bad++; $display("FAIL wrap_ff got=%h exp=ff", rv); end
    do_write(8'h80, 8'hFF, 2);
    read_at(8'hF2, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL wrap_00 got=%h exp=00", rv); end
    total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL wrap_cfg got=%h exp=%h", cfg, model_cfg()); end
  endtask

  task automatic test_reset_capture();
    do_write(8'h04, 8'hC3, 2);
    total++; if (cfg[39:32] !== 8'hC3) begin bad++; $display("FAIL cap_pre got=%h exp=c3", cfg[39:32]); end
    @(negedge clk); bus.addr = 8'h06; bus.wdata = 8'hE7; bus.wr_en_wdata = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL cap_rst_cfg got=%h exp=%h", cfg, model_cfg()); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL cap_rst_wr_addr got=%h exp=00", wr_addr); end
    total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL cap_rst_rdata got=%h exp=00", bus.rdata); end
    total++; if (wr_strobe !== 1'b0 || txn_done !== 1'b0 || irq !== 1'b0) begin
      bad++; $display("FAIL cap_rst_pulses strobe=%b txn=%b irq=%b exp=0", wr_strobe, txn_done, irq); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.wr_en_wdata = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (cfg !== model_cfg()) begin bad++; $display("FAIL cap_nocommit got=%h exp=%h", cfg, model_cfg()); end
    read_at(8'hF2, rv);
    total++; if (rv !== 8'h00) begin bad++; $display("FAIL cap_count got=%h exp=00", rv); end
  endtask

  initial begin
    bus.i2c_active = 1'b0; bus.wr_en_wdata = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
    model_reset();
    test_reset();
    test_write();
    test_read_filter();
    test_irq();
    test_txn_done();
    test_back_to_back();
    test_reset_hold();
    test_count_wrap();
    test_reset_capture();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL pending_commits got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
